// File: rtl/ex_stage_unit_if.sv
// OF-latch to EX-stage bundle: operands and control in, EX/MA latch contents
// plus front-end stall/redirect out.
interface ex_stage_unit_if;
    logic [31:0] inst_in;
    logic [31:0] pc_in;
    logic [31:0] branchTarget_in;
    logic [31:0] OP1_in;
    logic [31:0] OP2_in;
    logic [31:0] B_in;
    logic [21:0] control_in;

    logic        ex_stall;
    logic        isbranch_taken;
    logic [31:0] branch_pc;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic [31:0] aluResult;
    logic [31:0] B_out;
    logic [21:0] control_out;

    modport master (
        output inst_in, pc_in, branchTarget_in, OP1_in, OP2_in, B_in, control_in,
        input  ex_stall, isbranch_taken, branch_pc,
        input  pc_out, inst_out, aluResult, B_out, control_out
    );

    modport slave (
        input  inst_in, pc_in, branchTarget_in, OP1_in, OP2_in, B_in, control_in,
        output ex_stall, isbranch_taken, branch_pc,
        output pc_out, inst_out, aluResult, B_out, control_out
    );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: ALU, branch resolution on registered flags, iterative signed
// divider that stalls the front end, and the EX/MA pipeline latch.
module ex_stage_unit #(
    parameter logic [31:0] NOP_INST   = 32'h68000000,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic            clk,
    input logic            rst,
    ex_stage_unit_if.slave ex
);
    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_e;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      quo_q, quo_d, rem_q, rem_d, divisor_q, divisor_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dzero_q, dzero_d;
    logic             e_q, e_d, gt_q, gt_d;
    logic [31:0]      pc_out_q, pc_out_d, inst_out_q, inst_out_d;
    logic [31:0]      alu_q, alu_d, b_out_q, b_out_d;
    logic [21:0]      ctrl_q, ctrl_d;

    logic [21:0] c;
    logic        stall;
    logic [31:0] op1, op2, alu_res, quo_fix, rem_fix;
    logic [32:0] rem_shift;

    assign c   = ex.control_in;
    assign op1 = ex.OP1_in;
    assign op2 = ex.OP2_in;

    always_comb begin
        alu_res = '0;
        if (c[8])                        alu_res = ex.pc_in + 32'd4;
        else if (c[9] | c[1] | c[0])     alu_res = op1 + op2;
        else if (c[10])                  alu_res = op1 - op2;
        else if (c[12])                  alu_res = op1 * op2;
        else if (c[15])                  alu_res = op1 << op2[4:0];
        else if (c[16])                  alu_res = op1 >> op2[4:0];
        else if (c[17])                  alu_res = $signed(op1) >>> op2[4:0];
        else if (c[18])                  alu_res = op1 | op2;
        else if (c[19])                  alu_res = op1 & op2;
        else if (c[20])                  alu_res = ~op2;
        else if (c[21])                  alu_res = op2;
    end

    // Divide by zero yields all-ones quotient; remainder already equals the dividend.
    assign quo_fix   = dzero_q ? '1 : (qneg_q ? -quo_q : quo_q);
    assign rem_fix   = rneg_q ? -rem_q : rem_q;
    assign rem_shift = {rem_q, quo_q[31]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dzero_d   = dzero_q;
        stall     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (c[13] | c[14]) begin
                    stall     = 1'b1;
                    state_d   = RUN;
                    cnt_d     = '0;
                    quo_d     = op1[31] ? -op1 : op1;
                    rem_d     = '0;
                    divisor_d = op2[31] ? -op2 : op2;
                    qneg_d    = op1[31] ^ op2[31];
                    rneg_d    = op1[31];
                    dzero_d   = (op2 == '0);
                end
            end
            RUN: begin
                stall = 1'b1;
                if (rem_shift >= {1'b0, divisor_q}) begin
                    rem_d = rem_shift[31:0] - divisor_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        e_d        = e_q;
        gt_d       = gt_q;
        pc_out_d   = '0;
        inst_out_d = NOP_INST;
        alu_d      = '0;
        b_out_d    = '0;
        ctrl_d     = '0;
        if (!stall) begin
            pc_out_d   = ex.pc_in;
            inst_out_d = ex.inst_in;
            alu_d      = (state_q == DONE) ? (c[14] ? rem_fix : quo_fix) : alu_res;
            b_out_d    = ex.B_in;
            ctrl_d     = c;
            if (c[11]) begin
                e_d  = (op1 == op2);
                gt_d = ($signed(op1) > $signed(op2));
            end
        end
    end

    assign ex.ex_stall       = stall;
    assign ex.isbranch_taken = ~stall & (c[7] | (c[2] & e_q) | (c[3] & gt_q));
    assign ex.branch_pc      = c[4] ? op1 : ex.branchTarget_in;
    assign ex.pc_out         = pc_out_q;
    assign ex.inst_out       = inst_out_q;
    assign ex.aluResult      = alu_q;
    assign ex.B_out          = b_out_q;
    assign ex.control_out    = ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dzero_q    <= 1'b0;
            e_q        <= 1'b0;
            gt_q       <= 1'b0;
            pc_out_q   <= '0;
            inst_out_q <= NOP_INST;
            alu_q      <= '0;
            b_out_q    <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dzero_q    <= dzero_d;
            e_q        <= e_d;
            gt_q       <= gt_d;
            pc_out_q   <= pc_out_d;
            inst_out_q <= inst_out_d;
            alu_q      <= alu_d;
            b_out_q    <= b_out_d;
            ctrl_q     <= ctrl_d;
        end
    end
endmodule

// File: doc/ex_stage_unit.md
# ex_stage_unit

Execute stage of the five-stage pipeline, directly downstream of the operand-fetch (OF) latch. It consumes the OF latch outputs and computes the ALU result. Branches are resolved here, and the branch lock drives the upstream IF/OF latches. Division and modulo run on an iterative 32-cycle divider that stalls the front end. The results are registered into the EX/MA latch, which is held inside this block.

## Interface
Parameters:
- NOP_INST, 32'h68000000, encoding loaded into `inst_out` for bubbles and at reset.
- DIV_CYCLES, 32, number of divider iterations (one quotient bit per cycle).

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_in`  in  32  instruction from the OF latch.
- `pc_in`  in  32  PC from the OF latch.
- `branchTarget_in`  in  32  PC-relative target from the OF latch.
- `OP1_in`  in  32  first ALU operand.
- `OP2_in`  in  32  second ALU operand (immediate already muxed).
- `B_in`  in  32  store data.
- `control_in`  in  22  decoded control word. Bit map: 0 isSt, 1 isLd, 2 isBeq, 3 isBgt, 4 isRet, 5 isImmediate, 6 isWb, 7 isUbranch, 8 isCall, 9 isAdd, 10 isSub, 11 isCmp, 12 isMul, 13 isDiv, 14 isMod, 15 isLsl, 16 isLsr, 17 isAsr, 18 isOr, 19 isAnd, 20 isNot, 21 isMov. All zero means bubble.
- `ex_stall`  out  1  combinational; holds the IF/OF latches while the divider is busy.
- `isbranch_taken`  out  1  combinational; flushes the IF/OF latches (becomes `isbranch_lock_for_OF_latch`).
- `branch_pc`  out  32  combinational redirect PC.
- `pc_out`, `inst_out`, `aluResult`, `B_out`  out  32 each  EX/MA latch contents.
- `control_out`  out  22  EX/MA latch control word.

## Operation
- ALU, all 32-bit, result truncated to 32 bits:
  - add, ld and st: OP1+OP2.
  - sub: OP1−OP2.
  - mul: low 32 bits of the signed product.
  - lsl / lsr / asr: shift OP1 by OP2[4:0].
  - or / and: bitwise.
  - not: ~OP2.
  - mov: OP2.
  - cmp: result 0.
  - No op bit set: result 0.
- Flags register {E, GT}, reset 0. Updated only by a cmp that leaves EX:
  - E = (OP1==OP2).
  - GT = signed OP1 > OP2.
- Branch resolution, using registered flags:
  - taken = isUbranch | (isBeq & E) | (isBgt & GT).
  - branch_pc = isRet ? OP1_in : branchTarget_in.
  - taken is forced to 0 while `ex_stall` = 1.
  - Call writeback value: aluResult = pc_in + 4.
- Divider: signed, quotient truncates toward zero, remainder takes the sign of the dividend.
  - Divide by zero: quotient 32'hFFFFFFFF, remainder = dividend.
  - Most-negative ÷ −1: quotient 32'h80000000, remainder 0.
- Divider FSM:
  - IDLE: if isDiv or isMod is set, assert `ex_stall` combinationally, capture absolute operands and result signs, clear counter, go to RUN. Otherwise pass through.
  - RUN: one restoring step per cycle, `ex_stall` = 1. Go to DONE when counter == DIV_CYCLES−1.
  - DONE: `ex_stall` = 0. The OF latch still presents the same div/mod instruction. The EX/MA latch loads the sign-corrected quotient or remainder, and the FSM returns to IDLE. The instruction is not re-triggered.
- EX/MA latch:
  - Stall cycles (IDLE accept cycle and RUN): load a bubble (inst NOP_INST, control 0, other fields 0).
  - Otherwise: load the current instruction's pc, inst, result, B and control word.

## Timing
- Reset values:
  - pc_out, aluResult, B_out: 0.
  - control_out: 0.
  - inst_out: NOP_INST.
  - E, GT: 0.
  - FSM: IDLE, counter 0.
  - `ex_stall` and `isbranch_taken`: 0 in the cycle following reset.
- Non-divide instruction: 1-cycle latency, registered at the next edge.
- Divide instruction: `ex_stall` high for exactly 1+DIV_CYCLES cycles (33). The result appears in the EX/MA latch at the edge ending the DONE cycle, 34 edges after first presentation.
- Back-to-back divides: the second is accepted in the cycle after DONE, with no extra bubble.
- cmp immediately followed by beq/bgt: the flags written at the cmp edge are seen by the branch in the next cycle.
- Taken branch in EX: `isbranch_taken` is high for that cycle only. The instruction itself still enters the EX/MA latch normally.
- `rst` during RUN: FSM returns to IDLE at that edge, no result is written, and `ex_stall` is 0 next cycle.
- A bubble (control 0) in IDLE never starts the divider.

## Test plan
- Reset: hold `rst` 2 cycles → inst_out=32'h68000000, all other outputs 0, `ex_stall`=0.
- Present add with OP1=7, OP2=5 → aluResult=12 at the next edge. Then lsl with OP1=1, OP2=32'h21 → aluResult=2 (only OP2[4:0]=1 is used).
- cmp OP1=−3, OP2=−3, then beq with branchTarget 0x40 → isbranch_taken=1, branch_pc=0x40. Then bgt → not taken.
- div OP1=−7, OP2=2 → `ex_stall` high 33 cycles with bubbles in EX/MA, then aluResult=32'hFFFFFFFD. mod of the same operands → 32'hFFFFFFFF.
- div by zero with OP1=9 → 32'hFFFFFFFF. mod by zero with OP1=9 → 9. 32'h80000000 ÷ −1 → 32'h80000000.
- Assert `rst` at RUN cycle 10 → `ex_stall`=0 next cycle, control_out=0, and a following add completes in 1 cycle.
